// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_pkg
// Description : Shared definitions for the data-memory load/store sequencer:
//               sign-mask bit positions, response error codes, FSM state
//               encoding, the LED address and the alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    // Bit positions inside the 4-bit sign_mask field
    localparam int c_SM_BYTE = 0;
    localparam int c_SM_HALF = 1;
    localparam int c_SM_WORD = 2;
    localparam int c_SM_SIGN = 3;

    // Response error codes returned to writeback
    localparam logic [1:0] c_ERR_OK       = 2'd0;
    localparam logic [1:0] c_ERR_MISALIGN = 2'd1;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'd2;

    // Memory-mapped LED register address
    localparam logic [31:0] c_LED_ADDR = 32'h0000_2000;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    // Word accesses need addr[1:0]==0, halfwords need addr[0]==0, bytes are
    // always aligned. Word takes priority if several size bits are set.
    function automatic logic f_misaligned(input logic [1:0] addr_lo,
                                          input logic [3:0] sign_mask);
        logic v_mis;
        v_mis = 1'b0;
        if (sign_mask[c_SM_WORD]) begin
            v_mis = (addr_lo != 2'b00);
        end else if (sign_mask[c_SM_HALF]) begin
            v_mis = addr_lo[0];
        end
        return v_mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_master_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : req_queue
// Description : Small synchronous FIFO holding pending load/store requests.
//               Occupancy is tracked with wrapping pointers plus an explicit
//               full bit, so push and pop may happen together even when full.
// Revision    : 1.0 - initial release
// ============================================================================
module req_queue #(
    parameter int QDEPTH = 2,
    parameter int WIDTH  = 69
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int c_PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [QDEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic               r_full;
    logic [c_PTR_W-1:0] w_wr_ptr_nxt;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;

    // Depth is a power of two, so pointer increments wrap naturally
    assign w_wr_ptr_nxt = r_wr_ptr + c_PTR_W'(1);
    assign w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(1);

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = r_full;
    assign empty    = (r_wr_ptr == r_rd_ptr) && !r_full;

    // Storage array; contents need no reset because occupancy gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and full-flag maintenance
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
        end else begin
            if (push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (push && !pop) begin
                r_full <= (w_wr_ptr_nxt == r_rd_ptr);
            end else if (pop && !push) begin
                r_full <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_master
// Description : CPU-side load/store sequencer for the stalling data memory.
//               Buffers pipeline requests, rejects misaligned accesses,
//               issues a single-cycle read/write strobe, follows the memory's
//               clk_stall rise and fall with a timeout, and returns the
//               result to writeback as a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_master
    import data_mem_pkg::*;
#(
    parameter int QDEPTH        = 2,
    parameter int STALL_TIMEOUT = 15,
    parameter int ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_sign_mask,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err,
    output logic              busy,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_write_data,
    output logic              mem_memwrite,
    output logic              mem_memread,
    output logic [3:0]        mem_sign_mask,
    input  logic [31:0]       mem_read_data,
    input  logic              mem_clk_stall
);

    localparam int c_REQ_W = 1 + ADDR_W + 32 + 4;
    localparam int c_CNT_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(STALL_TIMEOUT);

    state_t              r_state;
    state_t              w_next;

    logic                w_push;
    logic                w_pop;
    logic                w_q_full;
    logic                w_q_empty;
    logic [c_REQ_W-1:0]  w_q_in;
    logic [c_REQ_W-1:0]  w_q_head;

    logic                w_head_write;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [31:0]         w_head_wdata;
    logic [3:0]          w_head_mask;

    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_mask;

    logic [c_CNT_W-1:0]  r_cnt;
    logic                w_cnt_clr;
    logic                w_cnt_inc;
    logic                w_timeout;

    logic                w_resp_load;
    logic [1:0]          w_resp_err;
    logic [31:0]         w_resp_data;
    logic [31:0]         r_resp_rdata;
    logic [1:0]          r_resp_err;

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    // A full queue still accepts when the head is leaving this cycle
    assign req_ready = !w_q_full || w_pop;
    assign w_push    = req_valid && req_ready;
    assign w_q_in    = {req_write, req_addr, req_wdata, req_sign_mask};

    req_queue #(
        .QDEPTH (QDEPTH),
        .WIDTH  (c_REQ_W)
    ) u_req_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_q_in),
        .pop_data  (w_q_head),
        .full      (w_q_full),
        .empty     (w_q_empty)
    );

    assign w_head_write = w_q_head[c_REQ_W-1];
    assign w_head_addr  = w_q_head[c_REQ_W-2 -: ADDR_W];
    assign w_head_wdata = w_q_head[35:4];
    assign w_head_mask  = w_q_head[3:0];

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    assign w_timeout = (r_cnt == c_TIMEOUT);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state control decisions
    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_resp_load = 1'b0;
        w_resp_err  = c_ERR_OK;
        w_resp_data = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (!w_q_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (f_misaligned(r_addr[1:0], r_mask)) begin
                    w_resp_load = 1'b1;
                    w_resp_err  = c_ERR_MISALIGN;
                    w_next      = ST_RESP;
                end else begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cnt_clr = 1'b1;
                w_next    = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                // A stall that is already high counts as the rise
                if (mem_clk_stall) begin
                    w_cnt_clr = 1'b1;
                    w_next    = ST_WAIT_LO;
                end else if (w_timeout) begin
                    w_resp_load = 1'b1;
                    w_resp_err  = c_ERR_TIMEOUT;
                    w_next      = ST_RESP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!mem_clk_stall) begin
                    w_resp_load = 1'b1;
                    w_resp_data = r_write ? 32'd0 : mem_read_data;
                    w_next      = ST_RESP;
                end else if (w_timeout) begin
                    w_resp_load = 1'b1;
                    w_resp_err  = c_ERR_TIMEOUT;
                    w_next      = ST_RESP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Latch the launched request into the memory-facing registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_mask  <= 4'd0;
        end else if (w_pop) begin
            r_write <= w_head_write;
            r_addr  <= w_head_addr;
            r_wdata <= w_head_wdata;
            r_mask  <= w_head_mask;
        end
    end

    // Wait-phase cycle counter, restarted at the entry of each wait phase
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Response registers only change when a result is produced, so the
    // data stays stable between completion pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_resp_rdata <= 32'd0;
            r_resp_err   <= c_ERR_OK;
        end else if (w_resp_load) begin
            r_resp_rdata <= w_resp_data;
            r_resp_err   <= w_resp_err;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Strobes are decoded from the state register, so they exist only in
    // the single ISSUE cycle and drop on the edge that leaves it
    assign mem_memread    = (r_state == ST_ISSUE) && !r_write;
    assign mem_memwrite   = (r_state == ST_ISSUE) &&  r_write;
    assign mem_addr       = 32'(r_addr);
    assign mem_write_data = r_wdata;
    assign mem_sign_mask  = r_mask;

    assign resp_valid     = (r_state == ST_RESP);
    assign resp_rdata     = r_resp_rdata;
    assign resp_err       = r_resp_err;
    assign busy           = !w_q_empty || (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_master
// Description : Self-checking bench for data_mem_master. A behavioural
//               memory responder drives the stall handshake; a reference
//               model derives each response's value, error and cycle from
//               the alignment rules and the nominal handshake timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_master;

    localparam int QDEPTH        = 2;
    localparam int STALL_TIMEOUT = 15;
    localparam int ADDR_W        = 32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_sign_mask;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data;
    logic        mem_clk_stall;

    typedef struct { int cyc; logic [31:0] rdata; logic [1:0] err; } resp_t;
    typedef struct { logic w; logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask; } strb_t;
    typedef struct { int n; logic [31:0] rdata; } plan_t;

    resp_t exp_resp[$];
    resp_t obs_resp[$];
    strb_t exp_strb[$];
    strb_t obs_strb[$];
    plan_t mem_plan[$];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int rd_cycles = 0;
    int wr_cycles = 0;
    int exp_rd    = 0;
    int exp_wr    = 0;
    int last_resp = -100;

    data_mem_master #(
        .QDEPTH        (QDEPTH),
        .STALL_TIMEOUT (STALL_TIMEOUT),
        .ADDR_W        (ADDR_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_sign_mask  (req_sign_mask),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .busy           (busy),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_sign_mask  (mem_sign_mask),
        .mem_read_data  (mem_read_data),
        .mem_clk_stall  (mem_clk_stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Observe responses and strobes mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (resp_valid) obs_resp.push_back('{cyc, resp_rdata, resp_err});
            if (mem_memread) rd_cycles++;
            if (mem_memwrite) wr_cycles++;
            if (mem_memread || mem_memwrite)
                obs_strb.push_back('{mem_memwrite, mem_addr, mem_write_data, mem_sign_mask});
        end
    end

    // Memory responder: n stall cycles after the strobe, then data with
    // stall low; n == 0 means the memory never answers
    initial begin
        plan_t e;
        mem_clk_stall = 1'b0;
        mem_read_data = 32'd0;
        forever begin
            @(negedge clk);
            if (reset_n && (mem_memread || mem_memwrite) && mem_plan.size() > 0) begin
                e = mem_plan.pop_front();
                if (e.n > 0) begin
                    @(posedge clk); #1 mem_clk_stall = 1'b1;
                    repeat (e.n - 1) begin @(posedge clk); #1; end
                    @(posedge clk); #1 mem_clk_stall = 1'b0; mem_read_data = e.rdata;
                    @(posedge clk); #1 mem_read_data = $urandom;
                end
            end
        end
    end

    // Push one request and record what the reference model expects of it
    task automatic send(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, input int n, input logic [31:0] rdata,
                        input bit want_resp, output int pc);
        bit          mis;
        bit          ok;
        int          idle;
        int          lat;
        logic [31:0] e_data;
        logic [1:0]  e_err;
        if (mask[2])      mis = (addr % 4) != 0;
        else if (mask[1]) mis = (addr % 2) != 0;
        else              mis = 1'b0;
        if (!mis) begin
            mem_plan.push_back('{n, rdata});
            exp_strb.push_back('{w, addr, wdata, mask});
            if (w) exp_wr++; else exp_rd++;
        end
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = addr;
        req_wdata = wdata; req_sign_mask = mask;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) chk("req_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        pc = cyc;
        // Launch from IDLE once both pushed and the previous response is done
        idle = (pc > last_resp + 1) ? pc : last_resp + 1;
        if (mis)         lat = 2;
        else if (n == 0) lat = STALL_TIMEOUT + 4;
        else             lat = 4 + n;
        last_resp = idle + lat;
        e_err  = mis ? 2'd1 : (n == 0 ? 2'd2 : 2'd0);
        e_data = (w || e_err != 2'd0) ? 32'd0 : rdata;
        if (want_resp) exp_resp.push_back('{idle + lat, e_data, e_err});
    endtask

    // Wait for all expected responses and compare everything in order
    task automatic drain(input string tag);
        int    guard;
        resp_t e;
        resp_t o;
        strb_t es;
        strb_t os;
        guard = 0;
        while (obs_resp.size() < exp_resp.size() && guard < 3000) begin
            @(negedge clk); guard++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_resp_count"}, 32'(obs_resp.size()), 32'(exp_resp.size()));
        while (exp_resp.size() > 0 && obs_resp.size() > 0) begin
            e = exp_resp.pop_front(); o = obs_resp.pop_front();
            chk({tag, "_resp_cycle"}, 32'(o.cyc), 32'(e.cyc));
            chk({tag, "_resp_rdata"}, o.rdata, e.rdata);
            chk({tag, "_resp_err"}, 32'(o.err), 32'(e.err));
        end
        exp_resp.delete(); obs_resp.delete();
        chk({tag, "_strobe_count"}, 32'(obs_strb.size()), 32'(exp_strb.size()));
        while (exp_strb.size() > 0 && obs_strb.size() > 0) begin
            es = exp_strb.pop_front(); os = obs_strb.pop_front();
            chk({tag, "_strobe_write"}, 32'(os.w), 32'(es.w));
            chk({tag, "_strobe_addr"}, os.addr, es.addr);
            chk({tag, "_strobe_wdata"}, os.wdata, es.wdata);
            chk({tag, "_strobe_mask"}, 32'(os.mask), 32'(es.mask));
        end
        exp_strb.delete(); obs_strb.delete();
        chk({tag, "_memread_cycles"}, 32'(rd_cycles), 32'(exp_rd));
        chk({tag, "_memwrite_cycles"}, 32'(wr_cycles), 32'(exp_wr));
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        chk({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_sign_mask = 4'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_memread", 32'(mem_memread), 32'd0);
        chk("rst_memwrite", 32'(mem_memwrite), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        chk("rst_mem_mask", 32'(mem_sign_mask), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Load word, nominal handshake
        send(1'b0, 32'h1004, 32'h0, 4'b0100, 2, 32'hDEADBEEF, 1'b1, pc);
        drain("lw");
        chk("lw_rdata_hold", resp_rdata, 32'hDEADBEEF);

        // Store byte
        send(1'b1, 32'h1001, 32'hAB, 4'b0001, 2, $urandom, 1'b1, pc);
        drain("sb");

        // Misaligned halfword load
        send(1'b0, 32'h1003, 32'h0, 4'b1010, 2, $urandom, 1'b1, pc);
        drain("lh_mis");

        // Timeout in WAIT_HI, followed by a queued store that completes
        send(1'b0, 32'h1008, 32'h0, 4'b0100, 0, 32'h0, 1'b1, pc);
        send(1'b1, 32'h100C, 32'h12345678, 4'b0100, 2, 32'h0, 1'b1, pc);
        drain("timeout");

        // Three back-to-back requests fill the queue
        send(1'b0, 32'h1010, 32'h0, 4'b0100, 2, 32'h11111111, 1'b1, pc);
        send(1'b0, 32'h1012, 32'h0, 4'b0010, 1, 32'h22222222, 1'b1, pc);
        send(1'b1, 32'h1013, 32'h33, 4'b0001, 3, 32'h0, 1'b1, pc);
        chk("b2b_ready_full", 32'(req_ready), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        drain("b2b");

        // Randomized traffic with random gaps
        for (int k = 0; k < 40; k++) begin
            int          sz;
            int          n;
            logic [3:0]  m;
            sz = $urandom_range(0, 2);
            m  = (sz == 0) ? 4'b0001 : (sz == 1) ? 4'b0010 : 4'b0100;
            if ($urandom_range(0, 1) == 1) m[3] = 1'b1;
            n  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            send(1'(($urandom_range(0, 1))), 32'h1000 + 32'($urandom_range(0, 255)),
                 $urandom, m, n, $urandom, 1'b1, pc);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain("rand");

        // Reset while waiting for stall to fall
        send(1'b0, 32'h1020, 32'h0, 4'b0100, 3, 32'hCAFEF00D, 1'b0, pc);
        while (cyc < pc + 4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_memread", 32'(mem_memread), 32'd0);
        chk("abort_memwrite", 32'(mem_memwrite), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_resp_rdata", resp_rdata, 32'd0);
        reset_n = 1'b1;
        last_resp = -100;
        repeat (12) @(negedge clk);
        chk("abort_no_resp", 32'(obs_resp.size()), 32'd0);
        drain("abort");

        // Recovery after the aborted request
        send(1'b0, 32'h2000, 32'h0, 4'b0100, 2, 32'h0000_00FF, 1'b1, pc);
        drain("recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
